// File: rtl/intdiv_mult.sv
// intdiv_mult -- sequential two's-complement multiplier, radix-2 Booth, one
// recoding step per clock behind a start/done handshake. Used to rebuild a
// divider's dividend from its quotient, divisor and (optionally) remainder.
//
// Optional feature macro: INTDIV_MULT_REM_EN
//   defined   : extra FIX cycle adds sext(r); p = x*y + r, latency N+2
//   undefined : p = x*y, latency N+1, r is ignored
//
// Parameters:
//   N     operand width in bits (>= 3)
// Ports:
//   clk   rising-edge clock
//   rst   synchronous reset, active-high
//   start request, sampled only in IDLE or DONE
//   x     signed multiplier (Booth-recoded), captured on accept
//   y     signed multiplicand, captured on accept
//   r     signed addend, captured on accept (REM_EN builds only)
//   busy  high while the multiply is in progress (RUN, FIX)
//   done  one-cycle pulse, p valid in that cycle
//   p     2N-bit signed result, held until the next result completes
module intdiv_mult #(
    parameter int N = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   x,
    input  logic [N-1:0]   y,
    input  logic [N-1:0]   r,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] p
);
    localparam int AW = 2 * N + 2;         // {upper N+1, x N, booth bit}
    localparam int CW = $clog2(N + 1);

`ifdef INTDIV_MULT_REM_EN
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif

    state_t          state, state_n;
    logic [AW-1:0]   acc, acc_n;
    logic [N-1:0]    ycap, ycap_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [2*N-1:0]  p_n;

`ifdef INTDIV_MULT_REM_EN
    logic [N-1:0]    rcap, rcap_n;
`else
    logic            unused_r;
    assign unused_r = ^r;
`endif

    // One Booth step: the upper field is N+1 bits wide, so adding or
    // subtracting the sign-extended multiplicand can never overflow, even
    // for x = y = -2^(N-1).
    logic [N:0]      upper, ysx, upper_add;
    logic [AW-1:0]   acc_step;

    assign upper = acc[AW-1:N+1];
    assign ysx   = {ycap[N-1], ycap};

    always_comb begin
        case (acc[1:0])
            2'b01:   upper_add = upper + ysx;
            2'b10:   upper_add = upper - ysx;
            default: upper_add = upper;
        endcase
    end

    // Arithmetic right shift of {upper_add, acc[N:0]}, dropping the old Booth bit.
    assign acc_step = {upper_add[N], upper_add, acc[N:1]};

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_n = state;
        acc_n   = acc;
        ycap_n  = ycap;
        cnt_n   = cnt;
        p_n     = p;
`ifdef INTDIV_MULT_REM_EN
        rcap_n  = rcap;
`endif
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    ycap_n  = y;
                    acc_n   = {{(N + 1){1'b0}}, x, 1'b0};
                    cnt_n   = CW'(N);
`ifdef INTDIV_MULT_REM_EN
                    rcap_n  = r;
`endif
                    state_n = RUN;
                end else if (state == DONE) begin
                    state_n = IDLE;
                end
            end
            RUN: begin
                acc_n = acc_step;
                cnt_n = cnt - 1'b1;
                if (cnt == CW'(1)) begin
`ifdef INTDIV_MULT_REM_EN
                    state_n = FIX;
`else
                    state_n = DONE;
                    p_n     = acc_step[2*N:1];
`endif
                end
            end
`ifdef INTDIV_MULT_REM_EN
            FIX: begin
                acc_n[2*N:1] = acc[2*N:1] + {{N{rcap[N-1]}}, rcap};
                p_n          = acc_n[2*N:1];
                state_n      = DONE;
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            // NOTE: all datapath registers are reset too, so a reset mid-operation
            // discards the partial product and p reads zero afterwards.
            state <= IDLE;
            acc   <= '0;
            ycap  <= '0;
            cnt   <= '0;
            p     <= '0;
`ifdef INTDIV_MULT_REM_EN
            rcap  <= '0;
`endif
        end else begin
            state <= state_n;
            acc   <= acc_n;
            ycap  <= ycap_n;
            cnt   <= cnt_n;
            p     <= p_n;
`ifdef INTDIV_MULT_REM_EN
            rcap  <= rcap_n;
`endif
        end
    end

    // Decoded straight from the state register, so both are registered outputs.
`ifdef INTDIV_MULT_REM_EN
    assign busy = (state == RUN) || (state == FIX);
`else
    assign busy = (state == RUN);
`endif
    assign done = (state == DONE);

endmodule

// File: tb/tb_intdiv_mult.sv
// Self-checking bench for intdiv_mult (N=5). Expected products come from a
// signed reference model and go through a scoreboard queue: pushed when a
// request is driven, popped when done is observed. Inputs are driven and
// outputs sampled on the falling edge.
module tb_intdiv_mult;
    localparam int N = 5;
    localparam int W = 2 * N;
`ifdef INTDIV_MULT_REM_EN
    localparam int LAT    = N + 2;
    localparam bit REM_EN = 1'b1;
`else
    localparam int LAT    = N + 1;
    localparam bit REM_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] x, y, r;
    logic         busy, done;
    logic [W-1:0] p;

    int           checks = 0;
    int           errors = 0;
    int           cyc    = 0;
    logic [W-1:0] exp_q[$];

    intdiv_mult #(.N(N)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .x    (x),
        .y    (y),
        .r    (r),
        .busy (busy),
        .done (done),
        .p    (p)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] model(input logic signed [N-1:0] a,
                                           input logic signed [N-1:0] b,
                                           input logic signed [N-1:0] c);
        logic signed [W-1:0] m;
        m = a * b;
        if (REM_EN) m = m + c;
        return m;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One request from a falling edge; waits (bounded) for done and checks
    // latency, busy length, product, the done pulse width and p holding.
    task automatic run_op(input string tag, input logic [N-1:0] xi,
                          input logic [N-1:0] yi, input logic [N-1:0] ri);
        int           lat;
        int           nbusy;
        logic [W-1:0] e;
        x = xi; y = yi; r = ri; start = 1'b1;
        exp_q.push_back(model(xi, yi, ri));
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        nbusy = 0;
        while (!done && lat < 60) begin
            if (busy) nbusy++;
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, LAT);
        check({tag, "_busy_cycles"}, nbusy, LAT - 1);
        e = exp_q.pop_front();
        check({tag, "_p"}, p, e);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 1'b0);
        check({tag, "_p_hold"}, p, e);
    endtask

    initial begin : stim
        int ndone;
        int last;
        int guard;
        int seen;

        rst = 1'b1; start = 1'b0; x = '0; y = '0; r = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_p", p, '0);

        run_op("pos_pos", 5'd7, 5'd3, 5'd0);             // 21
        run_op("neg_pos", 5'b11001, 5'd3, 5'd0);         // -21
        run_op("pos_neg", 5'd5, 5'b11101, 5'd0);         // -15
        run_op("min_min", 5'b10000, 5'b10000, 5'd0);     // 256
        run_op("min_max", 5'b10000, 5'd15, 5'd0);        // -240
        run_op("zero_min", 5'd0, 5'b10000, 5'd0);        // 0
        run_op("r_input", 5'd7, 5'd3, 5'd5);             // 21, or 26 with r

        // start held high: back-to-back results every LAT cycles; x changed
        // while busy only shows up at the next accept.
        x = 5'd2; y = 5'd3; r = 5'd0; start = 1'b1;
        exp_q.push_back(model(5'd2, 5'd3, 5'd0));
        @(negedge clk);
        @(negedge clk);
        x = 5'd9;
        exp_q.push_back(model(5'd9, 5'd3, 5'd0));
        exp_q.push_back(model(5'd9, 5'd3, 5'd0));
        ndone = 0; last = 0; guard = 0;
        while (ndone < 3 && guard < 100) begin
            if (done) begin
                ndone++;
                check("held_p", p, exp_q.pop_front());
                if (ndone > 1) check("held_interval", cyc - last, LAT);
                last = cyc;
                if (ndone == 3) start = 1'b0;
            end
            @(negedge clk);
            guard++;
        end
        check("held_count", ndone, 3);
        exp_q.delete();
        @(negedge clk);

        // reset two cycles into an operation: everything cleared, no done follows
        x = 5'd7; y = 5'd3; r = 5'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_p", p, '0);
        seen = 0;
        repeat (LAT + 3) begin
            if (done || busy) seen++;
            @(negedge clk);
        end
        check("midrst_no_done", seen, 0);
        run_op("after_rst", 5'd7, 5'd3, 5'd0);           // 21

`ifdef INTDIV_MULT_REM_EN
        run_op("rem_pos", 5'd2, 5'd3, 5'd1);             // 7
        run_op("rem_neg", 5'b11101, 5'd5, 5'b11111);     // -16
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
